// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation datapath.
// Holds the default operand width, the sequencer state encoding and reference keys.
package rsa_pkg;

  localparam int unsigned BITS_DEFAULT = 128;

  typedef enum logic [3:0] {
    StIdle,
    StCheck,
    StScan,
    StSq,
    StWaitSq,
    StMul,
    StWaitMul,
    StFinish,
    StDrain
  } state_e;

  // Small and 128-bit test keys (N, public E, private D).
  localparam logic [127:0] N16  = 128'd1189;
  localparam logic [127:0] E16  = 128'd3;
  localparam logic [127:0] D16  = 128'd187;
  localparam logic [127:0] N128 = 128'd20769187434139322034329832130609147;
  localparam logic [127:0] E128 = 128'd17;
  localparam logic [127:0] D128 = 128'd18325753618358223281893785584271353;

endpackage

// File: rtl/modexp_ctrl_if.sv
// Host-side (GO/M/E/N/RESULT) and multiplier-side (MUL_*) signals of the modexp sequencer.
// master is the sequencer's view; slave is the view of the surrounding stimulus and multiplier.
interface modexp_ctrl_if #(
  parameter int unsigned BITS = rsa_pkg::BITS_DEFAULT
);
  logic            GO;
  logic [BITS-1:0] M;
  logic [BITS-1:0] E;
  logic [BITS-1:0] N;
  logic [BITS-1:0] RESULT;
  logic            DONE;
  logic            BUSY;
  logic            ERR;
  logic            MUL_START;
  logic [BITS-1:0] MUL_A;
  logic [BITS-1:0] MUL_B;
  logic [BITS-1:0] MUL_P;
  logic            MUL_DONE;

  modport master (
    input  GO, M, E, N, MUL_P, MUL_DONE,
    output RESULT, DONE, BUSY, ERR, MUL_START, MUL_A, MUL_B
  );

  modport slave (
    output GO, M, E, N, MUL_P, MUL_DONE,
    input  RESULT, DONE, BUSY, ERR, MUL_START, MUL_A, MUL_B
  );
endinterface

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing M^E mod N through an external
// modular multiplier, one request in flight at a time.
module modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int unsigned BITS = BITS_DEFAULT,
  parameter int unsigned IW   = $clog2(BITS)
) (
  input logic           CLK,
  input logic           RESET_N,
  modexp_ctrl_if.master bus
);

  localparam logic [IW-1:0] IdxMax = IW'(BITS - 1);

  state_e          state_q, state_d;
  logic [BITS-1:0] m_q, m_d;
  logic [BITS-1:0] e_q, e_d;
  logic [BITS-1:0] n_q, n_d;
  logic [BITS-1:0] r_q, r_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [BITS-1:0] result_q, result_d;
  logic            err_q, err_d;
  logic [BITS-1:0] mul_a_q, mul_a_d;
  logic [BITS-1:0] mul_b_q, mul_b_d;
  logic            outstanding_q, outstanding_d;
  logic            mul_start;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= StIdle;
      m_q           <= '0;
      e_q           <= '0;
      n_q           <= '0;
      r_q           <= '0;
      idx_q         <= '0;
      result_q      <= '0;
      err_q         <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      outstanding_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      m_q           <= m_d;
      e_q           <= e_d;
      n_q           <= n_d;
      r_q           <= r_d;
      idx_q         <= idx_d;
      result_q      <= result_d;
      err_q         <= err_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      outstanding_q <= outstanding_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    m_d           = m_q;
    e_d           = e_q;
    n_d           = n_q;
    r_d           = r_q;
    idx_d         = idx_q;
    result_d      = result_q;
    err_d         = err_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    outstanding_d = outstanding_q;
    mul_start     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.GO && !outstanding_q) begin
          m_d     = bus.M;
          e_d     = bus.E;
          n_d     = bus.N;
          err_d   = 1'b0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (!bus.GO) begin
          state_d = StIdle;
        end else if (n_q < BITS'(2) || m_q >= n_q) begin
          err_d   = 1'b1;
          r_d     = '0;
          state_d = StFinish;
        end else if (e_q == '0) begin
          r_d     = BITS'(1);
          state_d = StFinish;
        end else begin
          idx_d   = IdxMax;
          state_d = StScan;
        end
      end
      StScan: begin
        if (!bus.GO) begin
          state_d = StIdle;
        end else if (e_q[idx_q]) begin
          // Leading one: R starts at M, skipping the trivial first square/multiply.
          r_d = m_q;
          if (idx_q == '0) begin
            state_d = StFinish;
          end else begin
            idx_d   = idx_q - IW'(1);
            state_d = StSq;
          end
        end else if (idx_q != '0) begin
          idx_d = idx_q - IW'(1);
        end else begin
          state_d = StFinish;
        end
      end
      StSq, StMul: begin
        if (!bus.GO) begin
          state_d = StIdle;
        end else begin
          mul_start = 1'b1;
          state_d   = (state_q == StSq) ? StWaitSq : StWaitMul;
        end
      end
      StWaitSq: begin
        if (!bus.GO) begin
          state_d = bus.MUL_DONE ? StIdle : StDrain;
        end else if (bus.MUL_DONE) begin
          r_d = bus.MUL_P;
          if (e_q[idx_q]) begin
            state_d = StMul;
          end else if (idx_q == '0) begin
            state_d = StFinish;
          end else begin
            idx_d   = idx_q - IW'(1);
            state_d = StSq;
          end
        end
      end
      StWaitMul: begin
        if (!bus.GO) begin
          state_d = bus.MUL_DONE ? StIdle : StDrain;
        end else if (bus.MUL_DONE) begin
          r_d = bus.MUL_P;
          if (idx_q == '0) begin
            state_d = StFinish;
          end else begin
            idx_d   = idx_q - IW'(1);
            state_d = StSq;
          end
        end
      end
      StFinish: begin
        if (!bus.GO) state_d = StIdle;
      end
      StDrain: begin
        if (bus.MUL_DONE) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Operands are staged on entry so they are already valid alongside MUL_START.
    if (state_d == StSq) begin
      mul_a_d = r_d;
      mul_b_d = r_d;
    end else if (state_d == StMul) begin
      mul_a_d = r_d;
      mul_b_d = m_q;
    end

    if (state_d == StFinish && state_q != StFinish) result_d = r_d;

    if (mul_start) begin
      outstanding_d = 1'b1;
    end else if (bus.MUL_DONE) begin
      outstanding_d = 1'b0;
    end
  end

  assign bus.MUL_START = mul_start;
  assign bus.MUL_A     = mul_a_q;
  assign bus.MUL_B     = mul_b_q;
  assign bus.RESULT    = result_q;
  assign bus.ERR       = err_q;
  assign bus.DONE      = (state_q == StFinish);
  assign bus.BUSY      = (state_q != StIdle) && (state_q != StFinish);

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: behavioural multiplier with programmable latency, a right-to-left
// reference exponentiation and a scoreboard of expected results.
module tb_modexp_ctrl;
  import rsa_pkg::*;

  localparam int unsigned BITS = BITS_DEFAULT;
  typedef logic [BITS-1:0] word_t;
  typedef struct {
    word_t res;
    logic  err;
  } sb_t;

  logic CLK;
  logic RESET_N;

  modexp_ctrl_if #(.BITS(BITS)) bus ();
  modexp_ctrl #(.BITS(BITS)) dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));

  int    total = 0;
  int    bad = 0;
  sb_t   exp_q[$];
  int    start_cnt = 0;
  logic  proto_err = 1'b0;
  int    mul_lat = 1;
  word_t cur_n = '0;
  logic  mm_busy;
  int    mm_cnt;
  word_t mm_a, mm_b;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic word_t mulmod(input word_t a, input word_t b, input word_t n);
    logic [2*BITS-1:0] p;
    p = {{BITS{1'b0}}, a} * {{BITS{1'b0}}, b};
    p = p % {{BITS{1'b0}}, n};
    return p[BITS-1:0];
  endfunction

  function automatic word_t modexp_ref(input word_t m, input word_t e, input word_t n);
    word_t r, b;
    r = word_t'(1);
    b = m;
    for (int i = 0; i < BITS; i++) begin
      if (e[i]) r = mulmod(r, b, n);
      b = mulmod(b, b, n);
    end
    return r;
  endfunction

  function automatic int starts_ref(input word_t e);
    int msb, pop;
    msb = 0;
    pop = 0;
    for (int i = 0; i < BITS; i++) begin
      if (e[i]) begin
        msb = i;
        pop++;
      end
    end
    return (pop == 0) ? 0 : msb + pop - 1;
  endfunction

  // Behavioural modular multiplier; also flags protocol and operand-hold violations.
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mm_busy      <= 1'b0;
      mm_cnt       <= 0;
      mm_a         <= '0;
      mm_b         <= '0;
      bus.MUL_DONE <= 1'b0;
      bus.MUL_P    <= '0;
    end else begin
      bus.MUL_DONE <= 1'b0;
      if (mm_busy && (bus.MUL_A !== mm_a || bus.MUL_B !== mm_b)) proto_err <= 1'b1;
      if (bus.MUL_START) begin
        if (mm_busy) proto_err <= 1'b1;
        mm_busy   <= 1'b1;
        mm_cnt    <= mul_lat;
        mm_a      <= bus.MUL_A;
        mm_b      <= bus.MUL_B;
        start_cnt <= start_cnt + 1;
      end else if (mm_busy) begin
        if (mm_cnt <= 1) begin
          bus.MUL_DONE <= 1'b1;
          bus.MUL_P    <= mulmod(mm_a, mm_b, cur_n);
          mm_busy      <= 1'b0;
        end else begin
          mm_cnt <= mm_cnt - 1;
        end
      end
    end
  end

  task automatic run_op(input string name, input word_t m, input word_t e, input word_t n,
                        input int lat, input word_t exp_res, input logic exp_err,
                        input int exp_starts, input int max_cyc);
    sb_t  s;
    int   s0, cyc;
    logic ok;
    mul_lat = lat;
    cur_n   = n;
    s.res   = exp_res;
    s.err   = exp_err;
    exp_q.push_back(s);
    s0     = start_cnt;
    bus.M  = m;
    bus.E  = e;
    bus.N  = n;
    bus.GO = 1'b1;
    cyc    = 0;
    ok     = 1'b0;
    while (!ok && cyc < max_cyc) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (bus.DONE === 1'b1) ok = 1'b1;
      // Operands must already be latched; later input changes are ignored.
      if (cyc == 2) begin
        bus.M = ~m;
        bus.E = ~e;
        bus.N = ~n;
      end
    end
    s = exp_q.pop_front();
    total++;
    if (!ok) begin
      $display("FAIL %s done_timeout: DONE low after %0d cycles, required within %0d",
               name, cyc, max_cyc);
      bad++;
    end else begin
      total++;
      if (bus.RESULT !== s.res) begin
        $display("FAIL %s result: got %0h want %0h", name, bus.RESULT, s.res);
        bad++;
      end
      total++;
      if (bus.ERR !== s.err) begin
        $display("FAIL %s err: got %0b want %0b", name, bus.ERR, s.err);
        bad++;
      end
      total++;
      if (bus.BUSY !== 1'b0) begin
        $display("FAIL %s busy_at_done: got %0b want 0", name, bus.BUSY);
        bad++;
      end
      if (exp_starts >= 0) begin
        total++;
        if (start_cnt - s0 != exp_starts) begin
          $display("FAIL %s mul_starts: got %0d want %0d", name, start_cnt - s0, exp_starts);
          bad++;
        end
      end
      @(posedge CLK);
      #1;
      total++;
      if (bus.DONE !== 1'b1 || bus.RESULT !== s.res) begin
        $display("FAIL %s hold_with_go: done=%0b result=%0h want done=1 result=%0h",
                 name, bus.DONE, bus.RESULT, s.res);
        bad++;
      end
    end
    bus.GO = 1'b0;
    @(posedge CLK);
    #1;
    total++;
    if (bus.DONE !== 1'b0) begin
      $display("FAIL %s done_clear: got %0b want 0", name, bus.DONE);
      bad++;
    end
    total++;
    if (ok && bus.RESULT !== s.res) begin
      $display("FAIL %s result_held: got %0h want %0h", name, bus.RESULT, s.res);
      bad++;
    end
    total++;
    if (proto_err !== 1'b0) begin
      $display("FAIL %s mul_protocol: got violation=%0b want 0", name, proto_err);
      bad++;
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    bus.GO  = 1'b0;
    bus.M   = '0;
    bus.E   = '0;
    bus.N   = '0;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (bus.RESULT !== '0 || bus.DONE !== 1'b0 || bus.ERR !== 1'b0) begin
      $display("FAIL reset_status: result=%0h done=%0b err=%0b want 0 0 0",
               bus.RESULT, bus.DONE, bus.ERR);
      bad++;
    end
    total++;
    if (bus.BUSY !== 1'b0 || bus.MUL_START !== 1'b0) begin
      $display("FAIL reset_ctrl: busy=%0b mul_start=%0b want 0 0", bus.BUSY, bus.MUL_START);
      bad++;
    end
    total++;
    if (bus.MUL_A !== '0 || bus.MUL_B !== '0) begin
      $display("FAIL reset_operands: a=%0h b=%0h want 0 0", bus.MUL_A, bus.MUL_B);
      bad++;
    end
    #2 RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    total++;
    if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      $display("FAIL idle_after_reset: busy=%0b done=%0b want 0 0", bus.BUSY, bus.DONE);
      bad++;
    end
  endtask

  task automatic test_small_key();
    run_op("enc16", word_t'(462), E16, N16, 2, word_t'(224), 1'b0, 2, 2000);
    run_op("dec16", word_t'(224), D16, N16, 5, word_t'(462), 1'b0, 12, 3000);
  endtask

  task automatic test_key128();
    word_t c;
    c = modexp_ref(word_t'(16'hcafe), E128, N128);
    run_op("enc128", word_t'(16'hcafe), E128, N128, 1, c, 1'b0, 5, 2000);
    run_op("dec128", c, D128, N128, 3, modexp_ref(c, D128, N128), 1'b0, starts_ref(D128), 20000);
  endtask

  task automatic test_edges();
    word_t e_top;
    e_top = '0;
    e_top[BITS-1] = 1'b1;
    e_top[0] = 1'b1;
    run_op("e_zero", word_t'(5), '0, N16, 1, word_t'(1), 1'b0, 0, BITS + 2);
    run_op("n_one", '0, word_t'(3), word_t'(1), 1, '0, 1'b1, 0, BITS + 2);
    run_op("m_eq_n", N16, word_t'(3), N16, 1, '0, 1'b1, 0, BITS + 2);
    run_op("e_one", word_t'(7), word_t'(1), N16, 1, word_t'(7), 1'b0, 0, BITS + 2);
    run_op("e_top", word_t'(2), e_top, N16, 1, modexp_ref(word_t'(2), e_top, N16), 1'b0,
           BITS, 2000);
  endtask

  task automatic test_back_to_back();
    word_t m, e;
    int    lat;
    for (int i = 0; i < 4; i++) begin
      m   = word_t'($urandom_range(0, 1188));
      e   = word_t'($urandom_range(1, 65535));
      lat = $urandom_range(1, 20);
      run_op("b2b", m, e, N16, lat, modexp_ref(m, e, N16), 1'b0, starts_ref(e), 2000);
    end
  endtask

  task automatic test_abort_drain();
    int   s0, s1, cyc;
    logic seen_start, seen_mdone, seen_done;
    mul_lat = 10;
    cur_n   = N16;
    bus.M   = word_t'(462);
    bus.E   = D16;
    bus.N   = N16;
    bus.GO  = 1'b1;
    s0 = start_cnt;
    seen_start = 1'b0;
    cyc = 0;
    while (!seen_start && cyc < 300) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (start_cnt != s0) seen_start = 1'b1;
    end
    total++;
    if (!seen_start) begin
      $display("FAIL abort_first_start: no MUL_START within %0d cycles", cyc);
      bad++;
    end
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    bus.GO = 1'b0;
    s1 = start_cnt;
    @(posedge CLK);
    #1;
    total++;
    if (bus.BUSY !== 1'b1) begin
      $display("FAIL drain_busy: got %0b want 1", bus.BUSY);
      bad++;
    end
    seen_mdone = 1'b0;
    seen_done  = 1'b0;
    cyc = 0;
    while (!seen_mdone && cyc < 40) begin
      if (bus.DONE === 1'b1) seen_done = 1'b1;
      if (bus.MUL_DONE === 1'b1) begin
        seen_mdone = 1'b1;
      end else begin
        @(posedge CLK);
        #1;
        cyc++;
      end
    end
    total++;
    if (!seen_mdone) begin
      $display("FAIL drain_mul_done: no MUL_DONE within %0d cycles", cyc);
      bad++;
    end
    repeat (3) begin
      @(posedge CLK);
      #1;
      if (bus.DONE === 1'b1) seen_done = 1'b1;
    end
    total++;
    if (bus.BUSY !== 1'b0) begin
      $display("FAIL drain_to_idle: busy=%0b want 0", bus.BUSY);
      bad++;
    end
    total++;
    if (seen_done) begin
      $display("FAIL abort_done: DONE got 1 want 0 throughout abort");
      bad++;
    end
    total++;
    if (start_cnt != s1) begin
      $display("FAIL drain_no_start: got %0d extra starts want 0", start_cnt - s1);
      bad++;
    end
    run_op("after_abort", word_t'(462), E16, N16, 4, word_t'(224), 1'b0, 2, 2000);
  endtask

  task automatic test_reset_mid_scan();
    cur_n   = N16;
    mul_lat = 1;
    bus.M   = word_t'(5);
    bus.E   = word_t'(1);
    bus.N   = N16;
    bus.GO  = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    total++;
    if (bus.BUSY !== 1'b1) begin
      $display("FAIL scan_busy: got %0b want 1", bus.BUSY);
      bad++;
    end
    #3 RESET_N = 1'b0;
    #1;
    total++;
    if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.ERR !== 1'b0) begin
      $display("FAIL async_reset_status: busy=%0b done=%0b err=%0b want 0 0 0",
               bus.BUSY, bus.DONE, bus.ERR);
      bad++;
    end
    total++;
    if (bus.RESULT !== '0 || bus.MUL_START !== 1'b0 || bus.MUL_A !== '0) begin
      $display("FAIL async_reset_data: result=%0h start=%0b a=%0h want 0 0 0",
               bus.RESULT, bus.MUL_START, bus.MUL_A);
      bad++;
    end
    bus.GO = 1'b0;
    #7 RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    run_op("after_reset", word_t'(224), D16, N16, 7, word_t'(462), 1'b0, 12, 3000);
  endtask

  initial begin
    test_reset();
    test_small_key();
    test_key128();
    test_edges();
    test_back_to_back();
    test_abort_drain();
    test_reset_mid_scan();
    total++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_empty: got %0d entries want 0", exp_q.size());
      bad++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
- Sequencer for the RSA modular-exponentiation datapath: computes RESULT = M^E mod N by left-to-right square-and-multiply.
- Issues one modular-multiply request at a time to a shared modular multiplier (separate block) over a start/done handshake.
- Sits between the top-level stimulus/control logic (GO, M, E, N in; RESULT, DONE out) and the multiplier.

Parameters:
- BITS, 128, operand width of M, E, N, RESULT and of the multiplier operands.
- IW, $clog2(BITS), width of the exponent bit-index counter.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- GO  in  1  level start request; sampled in IDLE.
- M  in  BITS  message/base; must be < N.
- E  in  BITS  exponent.
- N  in  BITS  modulus.
- RESULT  out  BITS  M^E mod N; valid while DONE=1; held until the next accepted GO.
- DONE  out  1  operation complete (level).
- BUSY  out  1  high in every state except IDLE and FINISH.
- ERR  out  1  operand error on the last run; valid with DONE.
- MUL_START  out  1  one-cycle request pulse to the multiplier.
- MUL_A  out  BITS  multiplier operand A; held stable from MUL_START until MUL_DONE.
- MUL_B  out  BITS  multiplier operand B; same hold rule.
- MUL_P  in  BITS  (A*B) mod N from the multiplier; valid only when MUL_DONE=1.
- MUL_DONE  in  1  one-cycle completion pulse; never in the same cycle as MUL_START.

Behaviour:
- Reset (async assert, sync release): state=IDLE; RESULT=0; DONE=0; BUSY=0; ERR=0; MUL_START=0; MUL_A=0; MUL_B=0; bit index=0; outstanding flag=0.
- Operands M, E, N are latched into internal registers on GO acceptance. Later input changes do not affect the run.
- IDLE: GO=1 -> latch operands, go to CHECK.
- CHECK (1 cycle):
  - N<2 or M>=N -> ERR=1, R=0 -> FINISH.
  - E==0 -> R=1 -> FINISH.
  - Otherwise bit index = BITS-1 -> SCAN.
- SCAN: one bit per cycle, decrementing until E[idx]=1.
  - At the MSB: R=M (first square and multiply skipped).
  - idx==0 -> FINISH; else idx-=1 -> SQ.
- SQ: MUL_START=1, MUL_A=MUL_B=R -> WAIT_SQ.
- WAIT_SQ: on MUL_DONE, R=MUL_P.
  - E[idx]=1 -> MUL.
  - else idx==0 -> FINISH; else idx-=1 -> SQ.
- MUL: MUL_START=1, MUL_A=R, MUL_B=M -> WAIT_MUL.
- WAIT_MUL: on MUL_DONE, R=MUL_P; idx==0 -> FINISH; else idx-=1 -> SQ.
- Multiplier request count: (msb_index) squares + (popcount(E)-1) multiplies.
- FINISH: RESULT=R, DONE=1, BUSY=0; hold while GO=1. GO=0 -> IDLE; DONE clears the next cycle; RESULT and ERR stay held.
- Abort: GO=0 in CHECK/SCAN/SQ/MUL -> IDLE, DONE stays 0.
  - GO=0 in WAIT_SQ/WAIT_MUL -> DRAIN: wait for MUL_DONE, discard MUL_P, then IDLE. No new MUL_START is issued.
  - GO reasserted during DRAIN is ignored until IDLE.
- Reset mid-operation: immediate return to reset values. The multiplier is reset by the same RESET_N.
- idx is a down-counter and never wraps below 0. The idx==0 test precedes the decrement.
- Stalls: no timeout; WAIT states hold indefinitely awaiting MUL_DONE.

Decomposition:
- Shared package rsa_pkg holds:
  - the BITS default;
  - state enum (IDLE, CHECK, SCAN, SQ, WAIT_SQ, MUL, WAIT_MUL, FINISH, DRAIN);
  - test key constants: N16=1189, E16=3, D16=187, N128=20769187434139322034329832130609147, E128=17, D128=18325753618358223281893785584271353.
- No sub-module inside; the modular multiplier (mod_mult) is a separate peer block. The bench uses a behavioural mod_mult model with programmable latency of 1–20 cycles.

Test Plan:
- N=1189, E=3, M=0x1ce (462), GO held -> 2 MUL_START pulses; DONE=1, RESULT=224, ERR=0; GO low -> DONE=0 next cycle, RESULT still 224.
- N=1189, E=187, M=224 -> RESULT=462; MUL_START count = 7 squares + 5 multiplies = 12.
- 128-bit key: M=0xcafe, E=17 -> C; then decrypt with D128 -> RESULT=0xcafe; E=17 run issues exactly 5 MUL_STARTs.
- E=0 -> RESULT=1, no MUL_START. N=1 -> ERR=1, RESULT=0. M=N -> ERR=1. All cases reach DONE within BITS+2 cycles.
- GO dropped during WAIT_SQ with multiplier latency 10 -> DRAIN until MUL_DONE, IDLE; no further MUL_START; DONE never asserted; next GO gives a correct result.
- RESET_N pulsed low mid-SCAN, asynchronously to CLK -> all outputs return to 0 immediately; the following GO completes normally.
